// File: rtl/fsgn_arbiter.sv
// Two-requester arbiter in front of a single-precision sign-injection unit.
// One accepted operation per cycle lands in a single result register drained by res_ready.
module fsgn_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,

    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_y,
    output logic        res_id,
    output logic        res_err,
    output logic [15:0] done_cnt
);

    typedef enum logic [2:0] {
        OP_SGNJ  = 3'd0,
        OP_SGNJN = 3'd1,
        OP_SGNJX = 3'd2,
        OP_NEG   = 3'd3,
        OP_ABS   = 3'd4
    } op_e;

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_e;

    logic        res_valid_q, res_valid_d;
    logic [31:0] res_y_q,     res_y_d;
    logic        res_id_q,    res_id_d;
    logic        res_err_q,   res_err_d;
    logic [15:0] done_cnt_q,  done_cnt_d;
    prio_e       prio_q,      prio_d;

    logic        can_accept;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic        consume;

    logic        sel;
    logic [2:0]  sel_op;
    logic [31:0] sel_x1;
    logic [31:0] sel_x2;
    logic        fn_sign;
    logic        fn_err;
    logic [31:0] fn_y;

    // Grant depends only on valids, priority pointer and result-register space.
    always_comb begin
        can_accept = ~res_valid_q | res_ready;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (req0_valid && req1_valid) begin
            if ((FAIR != 0) && (prio_q == PRIO_REQ1)) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    // Gating with rstn keeps both readys low for the whole reset, not just after an edge.
    assign req0_ready = rstn & can_accept & gnt0;
    assign req1_ready = rstn & can_accept & gnt1;

    assign accept  = req0_ready | req1_ready;
    assign consume = res_valid_q & res_ready;

    always_comb begin
        sel    = req1_ready;
        sel_op = sel ? req1_op : req0_op;
        sel_x1 = sel ? req1_x1 : req0_x1;
        sel_x2 = sel ? req1_x2 : req0_x2;
    end

    always_comb begin
        fn_sign = sel_x1[31];
        fn_err  = 1'b0;
        case (sel_op)
            OP_SGNJ:  fn_sign = sel_x2[31];
            OP_SGNJN: fn_sign = ~sel_x2[31];
            OP_SGNJX: fn_sign = sel_x1[31] ^ sel_x2[31];
            OP_NEG:   fn_sign = ~sel_x1[31];
            OP_ABS:   fn_sign = 1'b0;
            default: begin
                fn_sign = sel_x1[31];
                fn_err  = 1'b1;
            end
        endcase
        fn_y = {fn_sign, sel_x1[30:0]};
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;
        done_cnt_d  = done_cnt_q;
        prio_d      = prio_q;

        if (consume) begin
            res_valid_d = 1'b0;
            done_cnt_d  = done_cnt_q + 16'd1;
        end

        // An accept on the same edge as a consume refills the register without a bubble.
        if (accept) begin
            res_valid_d = 1'b1;
            res_y_d     = fn_y;
            res_id_d    = sel;
            res_err_d   = fn_err;
            if ((FAIR != 0) && (prio_e'(sel) == prio_q)) begin
                prio_d = (prio_q == PRIO_REQ0) ? PRIO_REQ1 : PRIO_REQ0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_id_q    <= 1'b0;
            res_err_q   <= 1'b0;
            done_cnt_q  <= '0;
            prio_q      <= PRIO_REQ0;
        end else begin
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
            done_cnt_q  <= done_cnt_d;
            prio_q      <= prio_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_fsgn_arbiter.sv
// Directed plus randomized bench for fsgn_arbiter (FAIR = 1) against a rule-level reference model.
module tb_fsgn_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
    logic        res_valid, res_ready, res_id, res_err;
    logic [31:0] res_y;
    logic [15:0] done_cnt;

    always #5 clk = ~clk;

    fsgn_arbiter #(.FAIR(1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_x1    (req0_x1),
        .req0_x2    (req0_x2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_x1    (req1_x1),
        .req1_x2    (req1_x2),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_y      (res_y),
        .res_id     (res_id),
        .res_err    (res_err),
        .done_cnt   (done_cnt)
    );

    int checks;
    int passed;
    bit quiet;

    // Reference state: the held result, consumed-result count and round-robin pointer.
    bit          m_valid;
    logic [31:0] m_y;
    bit          m_id;
    bit          m_err;
    logic [15:0] m_cnt;
    int          m_prio;
    logic        s0, s1;
    logic [31:0] held;

    // Returns {err, y}.
    function automatic logic [32:0] ref_fsgn(input logic [2:0] op, input logic [31:0] x1,
                                             input logic [31:0] x2);
        logic s;
        case (op)
            3'd0: s = x2[31];
            3'd1: s = ~x2[31];
            3'd2: s = x1[31] ^ x2[31];
            3'd3: s = ~x1[31];
            3'd4: s = 1'b0;
            default: return {1'b1, x1};
        endcase
        return {1'b0, s, x1[30:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_y     = '0;
        m_id    = 1'b0;
        m_err   = 1'b0;
        m_cnt   = '0;
        m_prio  = 0;
    endtask

    // Sample and check, then step the model across one rising edge.
    task automatic cycle();
        bit          can;
        int          w;
        logic [32:0] r;
        #1;
        can = !m_valid || res_ready;
        w   = -1;
        if (can) begin
            if (req0_valid && req1_valid) w = m_prio;
            else if (req0_valid)          w = 0;
            else if (req1_valid)          w = 1;
        end
        s0 = req0_ready;
        s1 = req1_ready;
        if (!quiet) begin
            chk("req0_ready", {31'b0, s0}, {31'b0, w == 0});
            chk("req1_ready", {31'b0, s1}, {31'b0, w == 1});
            chk("res_valid", {31'b0, res_valid}, {31'b0, m_valid});
            chk("res_y", res_y, m_y);
            chk("res_id", {31'b0, res_id}, {31'b0, m_id});
            chk("res_err", {31'b0, res_err}, {31'b0, m_err});
            chk("done_cnt", {16'b0, done_cnt}, {16'b0, m_cnt});
        end
        @(posedge clk);
        if (m_valid && res_ready) begin
            m_cnt++;
            m_valid = 1'b0;
        end
        if (w >= 0) begin
            r = (w == 0) ? ref_fsgn(req0_op, req0_x1, req0_x2)
                         : ref_fsgn(req1_op, req1_x1, req1_x2);
            m_valid = 1'b1;
            m_y     = r[31:0];
            m_err   = r[32];
            m_id    = (w == 1);
            if (w == m_prio) m_prio = 1 - m_prio;
        end
        #1;
    endtask

    initial begin
        logic [2:0] ops [3];
        ops[0] = 3'd3;
        ops[1] = 3'd4;
        ops[2] = 3'd2;
        checks = 0;
        passed = 0;
        quiet  = 1'b0;
        model_reset();

        // Reset with both requesters pending: nothing may be granted.
        rstn = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_x1 = '0; req0_x2 = '0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_x1 = '0; req1_x2 = '0;
        res_ready = 1'b1;
        #3;
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
        chk("rst_res_y", res_y, 32'd0);
        chk("rst_res_id", {31'b0, res_id}, 32'd0);
        chk("rst_res_err", {31'b0, res_err}, 32'd0);
        chk("rst_done_cnt", {16'b0, done_cnt}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", {31'b0, res_valid}, 32'd0);

        // SGNJ, accepted on the first edge after reset release.
        req1_valid = 1'b0;
        req0_op = 3'd0; req0_x1 = 32'h3F800000; req0_x2 = 32'hC0000000;
        @(negedge clk);
        rstn = 1'b1;
        cycle();
        chk("sgnj_y", res_y, 32'hBF800000);
        chk("sgnj_id", {31'b0, res_id}, 32'd0);
        chk("sgnj_err", {31'b0, res_err}, 32'd0);
        chk("sgnj_cnt0", {16'b0, done_cnt}, 32'd0);
        req0_valid = 1'b0;
        cycle();
        chk("sgnj_cnt1", {16'b0, done_cnt}, 32'd1);

        // NEG, ABS, SGNJX from requester 1, back to back.
        req1_valid = 1'b1; req1_x1 = 32'hC0490FDB; req1_x2 = 32'h80000000;
        for (int i = 0; i < 3; i++) begin
            req1_op = ops[i];
            cycle();
            chk("neg_abs_sgnjx_y", res_y, 32'h40490FDB);
            chk("neg_abs_sgnjx_id", {31'b0, res_id}, 32'd1);
        end
        req1_valid = 1'b0;

        // Illegal opcode passes x1 through and flags an error.
        req0_valid = 1'b1; req0_op = 3'd6; req0_x1 = 32'h12345678; req0_x2 = 32'hFFFFFFFF;
        cycle();
        chk("illegal_y", res_y, 32'h12345678);
        chk("illegal_err", {31'b0, res_err}, 32'd1);

        // Backpressure with both requesters valid.
        res_ready = 1'b0;
        req0_op = 3'd3; req0_x1 = $urandom; req1_valid = 1'b1; req1_op = 3'd1; req1_x2 = $urandom;
        held = res_y;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_no_ready", {30'b0, s0, s1}, 32'd0);
            chk("bp_y_stable", res_y, held);
        end
        res_ready = 1'b1;
        cycle();
        chk("bp_refill_valid", {31'b0, res_valid}, 32'd1);

        // Asynchronous reset while a result is held.
        res_ready = 1'b0;
        cycle();
        #2 rstn = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, res_valid}, 32'd0);
        chk("midrst_y", res_y, 32'd0);
        chk("midrst_cnt", {16'b0, done_cnt}, 32'd0);
        chk("midrst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_hold_valid", {31'b0, res_valid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // res_ready with no result is ignored; the discarded result stays uncounted.
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        cycle();
        cycle();
        chk("idle_cnt", {16'b0, done_cnt}, 32'd0);

        // Contention: round-robin ids 0,1,0,1 with exactly one ready each cycle.
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_op = 3'($urandom_range(0, 7)); req0_x1 = $urandom; req0_x2 = $urandom;
            req1_op = 3'($urandom_range(0, 7)); req1_x1 = $urandom; req1_x2 = $urandom;
            cycle();
            chk("rr_one_ready", {31'b0, s0 ^ s1}, 32'd1);
            chk("rr_id", {31'b0, res_id}, 32'(i % 2));
        end

        // Random traffic, including valids dropping without a grant.
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_op = 3'($urandom_range(0, 7)); req0_x1 = $urandom; req0_x2 = $urandom;
            req1_op = 3'($urandom_range(0, 7)); req1_x1 = $urandom; req1_x2 = $urandom;
            res_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        // Counter wrap after 65536 consumes.
        #2 rstn = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0; res_ready = 1'b1;
        req0_op = 3'd4; req0_x1 = 32'hDEADBEEF;
        quiet = 1'b1;
        repeat (65536) cycle();
        quiet = 1'b0;
        chk("wrap_ffff", {16'b0, done_cnt}, 32'h0000FFFF);
        cycle();
        chk("wrap_zero", {16'b0, done_cnt}, 32'h00000000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fsgn_arbiter.md
FSGN_ARBITER -- requirements
Module: fsgn_arbiter

Interface
REQ-001 SHALL have parameter: FAIR, default 1, 1 = round-robin grant, 0 = fixed priority to requester 0.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester presents an operation.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  operation accepted this cycle (valid & ready at clk edge).
REQ-006 SHALL have ports: req0_op / req1_op  input  3  opcode.
REQ-007 SHALL have ports: req0_x1, req0_x2, req1_x1, req1_x2  input  32  single-precision operands.
REQ-008 SHALL have port: res_valid  output  1  result register holds a result.
REQ-009 SHALL have port: res_ready  input  1  consumer takes the result (res_valid & res_ready at clk edge).
REQ-010 SHALL have port: res_y  output  32  result.
REQ-011 SHALL have port: res_id  output  1  index of the requester that issued the result.
REQ-012 SHALL have port: res_err  output  1  result came from an illegal opcode.
REQ-013 SHALL have port: done_cnt  output  16  count of results consumed.

Function
REQ-014 SHALL compute y[30:0] = x1[30:0] for every opcode.
REQ-015 SHALL compute y[31] per opcode: 0 SGNJ = x2[31]; 1 SGNJN = ~x2[31]; 2 SGNJX = x1[31]^x2[31]; 3 NEG = ~x1[31]; 4 ABS = 0.
REQ-016 SHALL, for opcodes 5-7, set y = x1 unchanged and res_err = 1; res_err SHALL be 0 for opcodes 0-4.
REQ-017 SHALL define can_accept = ~res_valid | res_ready; reqN_ready SHALL be 0 whenever can_accept = 0.
REQ-018 SHALL, with one requester valid and can_accept = 1, assert only that requester's ready.
REQ-019 SHALL, with both requesters valid and can_accept = 1, grant exactly one: the requester selected by pointer prio when FAIR = 1, requester 0 when FAIR = 0.
REQ-020 SHALL derive reqN_ready combinationally from valids, prio and can_accept, and SHALL NOT depend on req ops or operands.
REQ-021 SHALL, with FAIR = 1, toggle prio to the other requester on every accepted grant to the prio holder, and leave prio unchanged on grants to the non-holder.
REQ-022 SHALL load res_y, res_id and res_err, and set res_valid = 1, on the edge of acceptance (latency 1 cycle).
REQ-023 SHALL, on consume with no new accept, clear res_valid; on simultaneous consume and accept, keep res_valid = 1 and load the new result (no bubble).
REQ-024 SHALL hold res_y, res_id and res_err stable while res_valid = 1 and res_ready = 0.
REQ-025 SHALL increment done_cnt by 1 per consume, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL ignore res_ready while res_valid = 0, with no done_cnt change.
REQ-027 SHALL permit a requester to drop valid without being granted (no lock-in).

Reset
REQ-028 SHALL, while rstn = 0 and independent of clk, force res_valid = 0, res_y = 0, res_id = 0, res_err = 0, done_cnt = 0, prio = 0, req0_ready = 0, req1_ready = 0.
REQ-029 SHALL discard any held result when rstn is asserted mid-operation; that result SHALL NOT be counted.
REQ-030 SHALL permit the first acceptance on the first rising clk edge after rstn deasserts.

Verification
REQ-031 SHALL cover SGNJ: req0 op = 0, x1 = 0x3F800000, x2 = 0xC0000000, res_ready = 1 -> next cycle res_y = 0xBF800000, res_id = 0, res_err = 0, done_cnt 0 -> 1.
REQ-032 SHALL cover NEG, ABS and SGNJX: x1 = 0xC0490FDB; NEG -> 0x40490FDB; ABS -> 0x40490FDB; SGNJX with x2 = 0x80000000 -> 0x40490FDB.
REQ-033 SHALL cover contention with FAIR = 1: both valid every cycle, res_ready = 1 -> res_id sequence 0, 1, 0, 1, with exactly one ready per cycle.
REQ-034 SHALL cover backpressure: res_ready = 0 for 3 cycles with both valid -> both readys 0 and res_y stable; res_ready = 1 -> consume and accept on the same edge, res_valid stays 1.
REQ-035 SHALL cover illegal opcode: op = 6, x1 = 0x12345678 -> res_y = 0x12345678, res_err = 1.
REQ-036 SHALL cover reset and wrap: rstn low mid-hold -> res_valid = 0 immediately and held result never counted; 65536 consumes -> done_cnt = 0x0000.
